// File: rtl/awmf_prod_id_slave_sclk.sv
// Behavioural AWMF daisy-chain slave: answers PROD_ID reads with a fixed 60-bit word
// while passing chain data sdi->sdo through a 60-bit shifter, oversampled on clk.
module awmf_prod_id_slave_sclk #(
  parameter logic [9:0]  PROD_ID_ADDR = 10'h03E,
  parameter logic [47:0] PROD_ID_DATA = 48'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        sdi,
  output logic        sdo,
  output logic [59:0] rx_word,
  output logic        rx_valid,
  output logic        rx_len_err
);

  localparam logic [59:0] RESP_WORD = {2'b00, PROD_ID_ADDR, PROD_ID_DATA};

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_END} state_t;

  state_t      state, state_nx;
  logic [1:0]  sclk_sync, cs_sync, sdi_sync;
  logic        sclk_prev, cs_prev;
  logic [1:0]  init_cnt;
  logic        armed;
  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [59:0] sr, sr_nx;
  logic        din_s, din_nx;
  logic        sdo_nx;
  logic [15:0] bit_cnt, bit_cnt_nx;
  logic [5:0]  mod_cnt, mod_cnt_nx;
  logic [59:0] rx_word_nx;
  logic        rx_valid_nx, rx_len_err_nx;

  // sdi shares the sclk synchronizer depth so data is seen as it was at the pin edge.
  // armed blocks joining a frame whose cs_n was already low when reset released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      sdi_sync  <= 2'b00;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      init_cnt  <= 2'd0;
      armed     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      sdi_sync  <= {sdi_sync[0], sdi};
      sclk_prev <= sclk_sync[1];
      cs_prev   <= cs_sync[1];
      if (init_cnt != 2'd2) init_cnt <= init_cnt + 2'd1;
      if (init_cnt == 2'd2 && cs_sync[1]) armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign cs_fall   = armed & cs_prev & ~cs_sync[1];
  assign cs_rise   = cs_sync[1] & ~cs_prev;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx      = state;
    sr_nx         = sr;
    din_nx        = din_s;
    sdo_nx        = sdo;
    bit_cnt_nx    = bit_cnt;
    mod_cnt_nx    = mod_cnt;
    rx_word_nx    = rx_word;
    rx_valid_nx   = 1'b0;
    rx_len_err_nx = 1'b0;
    unique case (state)
      S_IDLE: begin
        sdo_nx = 1'b0;
        if (cs_fall) begin
          sr_nx      = RESP_WORD;
          sdo_nx     = RESP_WORD[59];
          bit_cnt_nx = 16'd0;
          mod_cnt_nx = 6'd0;
          state_nx   = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (sclk_rise) begin
          din_nx     = sdi_sync[1];
          bit_cnt_nx = (bit_cnt == 16'hFFFF) ? bit_cnt : bit_cnt + 16'd1;
          mod_cnt_nx = (mod_cnt == 6'd59) ? 6'd0 : mod_cnt + 6'd1;
        end
        // A nonzero bit count means a leading edge has been seen this frame.
        if (sclk_fall && bit_cnt != 16'd0) begin
          sr_nx  = {sr[58:0], din_s};
          sdo_nx = sr[58];
        end
        if (cs_rise) state_nx = S_END;
      end
      S_END: begin
        if (bit_cnt >= 16'd60 && mod_cnt == 6'd0) begin
          rx_word_nx  = sr;
          rx_valid_nx = 1'b1;
        end else begin
          rx_len_err_nx = 1'b1;
        end
        sdo_nx   = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sr and rx_word are plain registers, so they are reset with everything else.
      state      <= S_IDLE;
      sr         <= '0;
      din_s      <= 1'b0;
      sdo        <= 1'b0;
      bit_cnt    <= '0;
      mod_cnt    <= '0;
      rx_word    <= '0;
      rx_valid   <= 1'b0;
      rx_len_err <= 1'b0;
    end else begin
      state      <= state_nx;
      sr         <= sr_nx;
      din_s      <= din_nx;
      sdo        <= sdo_nx;
      bit_cnt    <= bit_cnt_nx;
      mod_cnt    <= mod_cnt_nx;
      rx_word    <= rx_word_nx;
      rx_valid   <= rx_valid_nx;
      rx_len_err <= rx_len_err_nx;
    end
  end

endmodule

// File: tb/tb_awmf_prod_id_slave_sclk.sv
// Directed bench: one standalone device plus a 4-device chain sharing one host bus.
module tb_awmf_prod_id_slave_sclk;

  localparam logic [59:0] CMD    = {2'b00, 10'h03E, 48'h0};
  localparam logic [59:0] RESP_S = {2'b00, 10'h03E, 48'hABCD_EF01_2345};
  localparam logic [59:0] CMD_A  = 60'h123_4567_89AB_CDEF;
  localparam logic [59:0] CMD_B  = 60'h0A5_A5A5_A5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;

  logic        sdo_s, rx_valid_s, rx_len_err_s;
  logic [59:0] rx_word_s;
  logic [3:0]  c_sdo, c_valid, c_err;
  logic [59:0] c_word [4];

  int vectors = 0;
  int miscompares = 0;
  int vcnt_s = 0, ecnt_s = 0;
  int vcnt_c [4] = '{0, 0, 0, 0};
  int ecnt_c [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  awmf_prod_id_slave_sclk #(.PROD_ID_ADDR(10'h03E), .PROD_ID_DATA(48'hABCD_EF01_2345)) u_single (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .sdi(mosi), .sdo(sdo_s),
    .rx_word(rx_word_s), .rx_valid(rx_valid_s), .rx_len_err(rx_len_err_s)
  );

  for (genvar i = 0; i < 4; i++) begin : g_chain
    logic sdi_i;
    if (i == 0) begin : g_first
      assign sdi_i = mosi;
    end else begin : g_next
      assign sdi_i = c_sdo[i-1];
    end
    awmf_prod_id_slave_sclk #(.PROD_ID_ADDR(10'h03E),
                              .PROD_ID_DATA(48'h1111_1111_1111 * 48'(i + 1))) u_dev (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .sdi(sdi_i), .sdo(c_sdo[i]),
      .rx_word(c_word[i]), .rx_valid(c_valid[i]), .rx_len_err(c_err[i])
    );
  end

  always @(negedge clk) begin
    if (rx_valid_s) vcnt_s++;
    if (rx_len_err_s) ecnt_s++;
    for (int i = 0; i < 4; i++) begin
      if (c_valid[i]) vcnt_c[i]++;
      if (c_err[i]) ecnt_c[i]++;
    end
  end

  task automatic frame_start();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Host sends data[n-1:0] MSB-first; samples both chain ends just before each rising sclk.
  task automatic send_bits(input int n, input logic [239:0] data,
                           output logic [239:0] got_s, output logic [239:0] got_c);
    got_s = '0;
    got_c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      mosi = data[i];
      repeat (4) @(negedge clk);
      got_s = {got_s[238:0], sdo_s};
      got_c = {got_c[238:0], c_sdo[3]};
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (sdo_s !== 1'b0) begin miscompares++; $display("FAIL reset_sdo: got %b want 0", sdo_s); end
    vectors++; if (rx_word_s !== 60'h0) begin miscompares++; $display("FAIL reset_rx_word: got %h want 0", rx_word_s); end
    vectors++; if (rx_valid_s !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid_s); end
    vectors++; if (rx_len_err_s !== 1'b0) begin miscompares++; $display("FAIL reset_rx_len_err: got %b want 0", rx_len_err_s); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    logic [239:0] gs, gc;
    int v0 = vcnt_s, e0 = ecnt_s;
    frame_start();
    send_bits(60, {180'h0, CMD}, gs, gc);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (rx_valid_s !== 1'b0) begin miscompares++; $display("FAIL single_valid_early: got %b want 0", rx_valid_s); end
    @(negedge clk);
    vectors++; if (rx_valid_s !== 1'b1) begin miscompares++; $display("FAIL single_valid_at_4clk: got %b want 1", rx_valid_s); end
    repeat (4) @(negedge clk);
    vectors++; if (gs[59:0] !== RESP_S) begin miscompares++; $display("FAIL single_resp: got %h want %h", gs[59:0], RESP_S); end
    vectors++; if (vcnt_s - v0 !== 1) begin miscompares++; $display("FAIL single_valid_count: got %0d want 1", vcnt_s - v0); end
    vectors++; if (ecnt_s - e0 !== 0) begin miscompares++; $display("FAIL single_err_count: got %0d want 0", ecnt_s - e0); end
    vectors++; if (rx_word_s !== CMD) begin miscompares++; $display("FAIL single_rx_word: got %h want %h", rx_word_s, CMD); end
  endtask

  task automatic test_chain();
    logic [239:0] gs, gc;
    int v0 [4];
    for (int i = 0; i < 4; i++) v0[i] = vcnt_c[i];
    frame_start();
    send_bits(240, {CMD, CMD, CMD, CMD}, gs, gc);
    frame_end();
    vectors++; if (gc[227:180] !== 48'h4444_4444_4444) begin miscompares++; $display("FAIL chain_dev3: got %h want 444444444444", gc[227:180]); end
    vectors++; if (gc[167:120] !== 48'h3333_3333_3333) begin miscompares++; $display("FAIL chain_dev2: got %h want 333333333333", gc[167:120]); end
    vectors++; if (gc[107:60] !== 48'h2222_2222_2222) begin miscompares++; $display("FAIL chain_dev1: got %h want 222222222222", gc[107:60]); end
    vectors++; if (gc[47:0] !== 48'h1111_1111_1111) begin miscompares++; $display("FAIL chain_dev0: got %h want 111111111111", gc[47:0]); end
    vectors++; if (gc[59:48] !== 12'h03E) begin miscompares++; $display("FAIL chain_dev0_hdr: got %h want 03e", gc[59:48]); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (c_word[i] !== CMD) begin miscompares++; $display("FAIL chain_rx_word%0d: got %h want %h", i, c_word[i], CMD); end
      vectors++; if (vcnt_c[i] - v0[i] !== 1) begin miscompares++; $display("FAIL chain_valid%0d: got %0d want 1", i, vcnt_c[i] - v0[i]); end
    end
  endtask

  task automatic test_length();
    logic [239:0] gs, gc;
    int v0 = vcnt_s, e0 = ecnt_s;
    frame_start();
    send_bits(59, {180'h0, CMD_A}, gs, gc);
    frame_end();
    vectors++; if (ecnt_s - e0 !== 1) begin miscompares++; $display("FAIL len59_err: got %0d want 1", ecnt_s - e0); end
    vectors++; if (vcnt_s - v0 !== 0) begin miscompares++; $display("FAIL len59_valid: got %0d want 0", vcnt_s - v0); end
    vectors++; if (rx_word_s !== CMD) begin miscompares++; $display("FAIL len59_rx_word: got %h want %h", rx_word_s, CMD); end
    v0 = vcnt_s;
    e0 = ecnt_s;
    frame_start();
    send_bits(120, {120'h0, CMD_A, CMD_B}, gs, gc);
    frame_end();
    vectors++; if (gs[119:60] !== RESP_S) begin miscompares++; $display("FAIL len120_resp: got %h want %h", gs[119:60], RESP_S); end
    vectors++; if (gs[59:0] !== CMD_A) begin miscompares++; $display("FAIL len120_passthru: got %h want %h", gs[59:0], CMD_A); end
    vectors++; if (vcnt_s - v0 !== 1) begin miscompares++; $display("FAIL len120_valid: got %0d want 1", vcnt_s - v0); end
    vectors++; if (ecnt_s - e0 !== 0) begin miscompares++; $display("FAIL len120_err: got %0d want 0", ecnt_s - e0); end
    vectors++; if (rx_word_s !== CMD_B) begin miscompares++; $display("FAIL len120_rx_word: got %h want %h", rx_word_s, CMD_B); end
  endtask

  task automatic test_idle();
    int v0 = vcnt_s, e0 = ecnt_s, ce0 = ecnt_c[3], busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mosi = i[0];
      repeat (4) @(negedge clk);
      if (sdo_s !== 1'b0 || c_sdo[3] !== 1'b0) busy++;
      sclk = ~sclk;
    end
    sclk = 1'b0;
    repeat (8) @(negedge clk);
    vectors++; if (busy !== 0) begin miscompares++; $display("FAIL idle_sdo: got %0d nonzero samples want 0", busy); end
    vectors++; if (vcnt_s - v0 + ecnt_s - e0 !== 0) begin miscompares++; $display("FAIL idle_pulses: got %0d want 0", vcnt_s - v0 + ecnt_s - e0); end
    vectors++; if (ecnt_c[3] - ce0 !== 0) begin miscompares++; $display("FAIL idle_chain_err: got %0d want 0", ecnt_c[3] - ce0); end
  endtask

  task automatic test_reset_mid();
    logic [239:0] gs, gc;
    int v0 = vcnt_s, e0 = ecnt_s;
    frame_start();
    send_bits(30, {180'h0, CMD} >> 30, gs, gc);
    repeat (4) @(negedge clk);
    // After 30 shifts the device drives response bit 29, which is 1.
    vectors++; if (sdo_s !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre_sdo: got %b want 1", sdo_s); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (sdo_s !== 1'b0) begin miscompares++; $display("FAIL rstmid_sdo: got %b want 0", sdo_s); end
    vectors++; if (rx_word_s !== 60'h0) begin miscompares++; $display("FAIL rstmid_rx_word: got %h want 0", rx_word_s); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_bits(30, {180'h0, CMD}, gs, gc);
    frame_end();
    vectors++; if (gs[29:0] !== 30'h0) begin miscompares++; $display("FAIL rstmid_not_joined: got %h want 0", gs[29:0]); end
    vectors++; if (vcnt_s - v0 + ecnt_s - e0 !== 0) begin miscompares++; $display("FAIL rstmid_pulses: got %0d want 0", vcnt_s - v0 + ecnt_s - e0); end
    v0 = vcnt_s;
    frame_start();
    send_bits(60, {180'h0, CMD_A}, gs, gc);
    frame_end();
    vectors++; if (gs[59:0] !== RESP_S) begin miscompares++; $display("FAIL rstmid_resp: got %h want %h", gs[59:0], RESP_S); end
    vectors++; if (rx_word_s !== CMD_A) begin miscompares++; $display("FAIL rstmid_rx_word_after: got %h want %h", rx_word_s, CMD_A); end
    vectors++; if (vcnt_s - v0 !== 1) begin miscompares++; $display("FAIL rstmid_valid: got %0d want 1", vcnt_s - v0); end
  endtask

  task automatic test_back_to_back();
    logic [239:0] gs, gc;
    int v0 = vcnt_s;
    frame_start();
    send_bits(60, {180'h0, CMD}, gs, gc);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (5) @(negedge clk);
    frame_start();
    send_bits(60, {180'h0, CMD_B}, gs, gc);
    frame_end();
    vectors++; if (gs[59:0] !== RESP_S) begin miscompares++; $display("FAIL b2b_resp: got %h want %h", gs[59:0], RESP_S); end
    vectors++; if (rx_word_s !== CMD_B) begin miscompares++; $display("FAIL b2b_rx_word: got %h want %h", rx_word_s, CMD_B); end
    vectors++; if (vcnt_s - v0 !== 2) begin miscompares++; $display("FAIL b2b_valid: got %0d want 2", vcnt_s - v0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_length();
    test_idle();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
